// File: rtl/cpu_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// cpu_ctrl_pkg
// Shared definitions for the multi-cycle MIPS control path: opcode values,
// control FSM state encodings and the mux/ALU select codes. The ALU control
// block imports the same package, so the codes stay consistent.
// -----------------------------------------------------------------------------
package cpu_ctrl_pkg;

    // Opcodes (IR[31:26])
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    // ALUOp codes
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    // ALUSrcB codes
    localparam logic [1:0] SRCB_B      = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    // pcSource codes
    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    // Control FSM states; encodings 14 and 15 are unused.
    typedef enum logic [3:0] {
        S_RST_IDLE = 4'd0,
        S_FETCH    = 4'd1,
        S_DECODE   = 4'd2,
        S_MEM_ADDR = 4'd3,
        S_MEM_RD   = 4'd4,
        S_MEM_WB   = 4'd5,
        S_MEM_WR   = 4'd6,
        S_EXEC     = 4'd7,
        S_R_WB     = 4'd8,
        S_BRANCH   = 4'd9,
        S_JUMP     = 4'd10,
        S_ADDI_EX  = 4'd11,
        S_ADDI_WB  = 4'd12,
        S_ILLEGAL  = 4'd13
    } state_t;

    // States that wait on mem_ready and are guarded by the watchdog.
    function automatic logic is_mem_state(input state_t st);
        return (st == S_FETCH) || (st == S_MEM_RD) || (st == S_MEM_WR);
    endfunction

endpackage

// File: rtl/cpu_multicycle_control.sv
// -----------------------------------------------------------------------------
// cpu_multicycle_control
// Multi-cycle MIPS control FSM. Sequences each instruction over 3-5 cycles,
// stalls in FETCH/MEM_RD/MEM_WR until mem_ready, traps undefined opcodes and
// aborts a memory access back to FETCH when the watchdog expires.
//
// Ports
//   clk, reset         rising-edge clock, asynchronous active-high reset
//   opcode             IR[31:26], stable outside FETCH
//   mem_ready          memory completes the current access this cycle
//   pcWrite .. ALUSrcA single-bit datapath enables / mux selects
//   ALUSrcB, ALUOp,
//   pcSource           2-bit mux / ALU operation selects (codes in cpu_ctrl_pkg)
//   illegal_op         1-cycle pulse, undefined opcode trapped
//   mem_fault          1-cycle registered pulse, memory watchdog expired
//   state              current FSM state for debug
// -----------------------------------------------------------------------------
module cpu_multicycle_control
    import cpu_ctrl_pkg::*;
#(
    parameter int OPCODE_W    = 6,
    parameter int MEM_TIMEOUT = 16,
    parameter int TMO_W       = 5
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                mem_ready,
    output logic                pcWrite,
    output logic                pcWriteCond,
    output logic                branchNe,
    output logic                IorD,
    output logic                memRead,
    output logic                memWrite,
    output logic                irWrite,
    output logic                memToReg,
    output logic                regWrite,
    output logic                regDst,
    output logic                ALUSrcA,
    output logic [1:0]          ALUSrcB,
    output logic [1:0]          ALUOp,
    output logic [1:0]          pcSource,
    output logic                illegal_op,
    output logic                mem_fault,
    output logic [3:0]          state
);

    // With the watchdog off this wraps to all-ones but is never used.
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(MEM_TIMEOUT - 1);

    state_t            r_state;
    state_t            w_next_state;
    logic [TMO_W-1:0]  r_tmo_cnt;
    logic              r_mem_fault;
    logic              w_mem_wait;
    logic              w_timeout;

    assign w_mem_wait = is_mem_state(r_state) && !mem_ready;
    // mem_ready on the expiry cycle is a normal completion, so only a real wait can expire.
    assign w_timeout  = (MEM_TIMEOUT != 0) && w_mem_wait && (r_tmo_cnt == TMO_LAST);

    // Next-state selection.
    always_comb begin
        w_next_state = S_FETCH;
        case (r_state)
            S_RST_IDLE: w_next_state = S_FETCH;
            S_FETCH: begin
                if (mem_ready) w_next_state = S_DECODE;
                else           w_next_state = S_FETCH;
            end
            S_DECODE: begin
                case (opcode)
                    OP_RTYPE:       w_next_state = S_EXEC;
                    OP_LW, OP_SW:   w_next_state = S_MEM_ADDR;
                    OP_BEQ, OP_BNE: w_next_state = S_BRANCH;
                    OP_J:           w_next_state = S_JUMP;
                    OP_ADDI:        w_next_state = S_ADDI_EX;
                    default:        w_next_state = S_ILLEGAL;
                endcase
            end
            S_MEM_ADDR: begin
                if (opcode == OP_LW)      w_next_state = S_MEM_RD;
                else if (opcode == OP_SW) w_next_state = S_MEM_WR;
                else                      w_next_state = S_FETCH;
            end
            S_MEM_RD: begin
                if (mem_ready)      w_next_state = S_MEM_WB;
                else if (w_timeout) w_next_state = S_FETCH;
                else                w_next_state = S_MEM_RD;
            end
            S_MEM_WR: begin
                if (mem_ready || w_timeout) w_next_state = S_FETCH;
                else                        w_next_state = S_MEM_WR;
            end
            S_EXEC:    w_next_state = S_R_WB;
            S_ADDI_EX: w_next_state = S_ADDI_WB;
            S_MEM_WB, S_R_WB, S_BRANCH, S_JUMP, S_ADDI_WB, S_ILLEGAL:
                       w_next_state = S_FETCH;
            default:   w_next_state = S_FETCH;
        endcase
    end

    // State register, watchdog counter and fault pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_RST_IDLE;
            r_tmo_cnt   <= '0;
            r_mem_fault <= 1'b0;
        end else begin
            r_state     <= w_next_state;
            r_mem_fault <= w_timeout;
            // Any state change (or a FETCH->FETCH timeout restart) starts a fresh wait.
            if (w_timeout || (w_next_state != r_state)) begin
                r_tmo_cnt <= '0;
            end else if (w_mem_wait && (MEM_TIMEOUT != 0)) begin
                r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);
            end else begin
                r_tmo_cnt <= r_tmo_cnt;
            end
        end
    end

    // Moore output decode; FETCH write enables follow mem_ready, BRANCH polarity follows opcode.
    always_comb begin
        pcWrite     = 1'b0;
        pcWriteCond = 1'b0;
        branchNe    = 1'b0;
        IorD        = 1'b0;
        memRead     = 1'b0;
        memWrite    = 1'b0;
        irWrite     = 1'b0;
        memToReg    = 1'b0;
        regWrite    = 1'b0;
        regDst      = 1'b0;
        ALUSrcA     = 1'b0;
        ALUSrcB     = SRCB_B;
        ALUOp       = ALUOP_ADD;
        pcSource    = PCSRC_ALU;
        illegal_op  = 1'b0;
        case (r_state)
            S_FETCH: begin
                memRead = 1'b1;
                ALUSrcB = SRCB_FOUR;
                irWrite = mem_ready;
                pcWrite = mem_ready;
            end
            S_DECODE:   ALUSrcB = SRCB_IMM_SH;
            S_MEM_ADDR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = SRCB_IMM;
            end
            S_MEM_RD: begin
                memRead = 1'b1;
                IorD    = 1'b1;
            end
            S_MEM_WB: begin
                memToReg = 1'b1;
                regWrite = 1'b1;
            end
            S_MEM_WR: begin
                memWrite = 1'b1;
                IorD     = 1'b1;
            end
            S_EXEC: begin
                ALUSrcA = 1'b1;
                ALUOp   = ALUOP_FUNCT;
            end
            S_R_WB: begin
                regDst   = 1'b1;
                regWrite = 1'b1;
            end
            S_BRANCH: begin
                ALUSrcA     = 1'b1;
                ALUOp       = ALUOP_SUB;
                pcSource    = PCSRC_ALUOUT;
                pcWriteCond = 1'b1;
                branchNe    = (opcode == OP_BNE);
            end
            S_JUMP: begin
                pcSource = PCSRC_JUMP;
                pcWrite  = 1'b1;
            end
            S_ADDI_EX: begin
                ALUSrcA = 1'b1;
                ALUSrcB = SRCB_IMM;
            end
            S_ADDI_WB:  regWrite   = 1'b1;
            S_ILLEGAL:  illegal_op = 1'b1;
            S_RST_IDLE: illegal_op = 1'b0;
            default:    illegal_op = 1'b0;
        endcase
    end

    assign mem_fault = r_mem_fault;
    assign state     = r_state;

endmodule
